// File: rtl/b06_pkg.sv
// Shared types and handler encodings for the b06 arbiter and b06 testbenches.
package b06_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_DRAIN
  } state_t;

  localparam logic [1:0] CC_NOP   = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;
  localparam logic [1:0] OUT_NORM = 2'b01;

  // Handler has returned to its normal, idle-looking output state.
  function automatic logic handler_normal(input logic [1:0] cc, input logic [1:0] us);
    return (us == OUT_NORM) && (cc == CC_NOP);
  endfunction

endpackage

// File: rtl/b06_rr_pick.sv
// Rotating-priority pick: first set request at or above ptr, wrapping modulo NREQ.
module b06_rr_pick
  import b06_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0] pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = IDW'((32'(ptr) + i) % NREQ);
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/b06_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one b06 handler.
// Optional handler-response timeout: define B06_ARB_TIMEOUT_EN.
module b06_arbiter
  import b06_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         ack,
  output logic                    eql,
  output logic                    cont_eql,
  input  logic [1:0]              cc_mux,
  input  logic [1:0]              uscite,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("b06_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n, gnt_n, next_ptr;
  logic [NREQ-1:0] ack_n;
  logic           eql_n, cont_eql_n, busy_n, err_n;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;

  b06_rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign next_ptr = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

`ifdef B06_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CW-1:0] cnt, cnt_n;
  logic          timeout;
  // Fires on the TIMEOUT-th cycle spent in S_REQ/S_DRAIN since entry.
  assign timeout = (cnt + CW'(1)) == CW'(TIMEOUT);
`endif

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    gnt_n      = gnt_idx;
    ack_n      = ack;
    eql_n      = eql;
    cont_eql_n = cont_eql;
    err_n      = 1'b0;
`ifdef B06_ARB_TIMEOUT_EN
    cnt_n      = (state == S_REQ || state == S_DRAIN) ? cnt + CW'(1) : '0;
`endif
    case (state)
      S_IDLE: begin
        ack_n      = '0;
        eql_n      = 1'b0;
        cont_eql_n = 1'b1;
        if (pick_valid) begin
          gnt_n      = pick_idx;
          eql_n      = 1'b1;
          cont_eql_n = 1'b0;
          state_n    = S_REQ;
        end
      end
      S_REQ: begin
        if (!req[gnt_idx]) begin
          eql_n   = 1'b0;
          state_n = S_DRAIN;
`ifdef B06_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end else if (cc_mux == CC_ACKIN) begin
          ack_n          = '0;
          ack_n[gnt_idx] = 1'b1;
          state_n        = S_ACK;
        end
`ifdef B06_ARB_TIMEOUT_EN
        else if (timeout) begin
          err_n      = 1'b1;
          eql_n      = 1'b0;
          ack_n      = '0;
          ptr_n      = next_ptr;
          cont_eql_n = 1'b1;
          state_n    = S_IDLE;
        end
`endif
      end
      S_ACK: begin
        if (!req[gnt_idx]) begin
          ack_n   = '0;
          eql_n   = 1'b0;
          state_n = S_DRAIN;
`ifdef B06_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      S_DRAIN: begin
        if (handler_normal(cc_mux, uscite)) begin
          ptr_n      = next_ptr;
          cont_eql_n = 1'b1;
          state_n    = S_IDLE;
        end
`ifdef B06_ARB_TIMEOUT_EN
        else if (timeout) begin
          err_n      = 1'b1;
          eql_n      = 1'b0;
          ack_n      = '0;
          ptr_n      = next_ptr;
          cont_eql_n = 1'b1;
          state_n    = S_IDLE;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      ack      <= '0;
      eql      <= 1'b0;
      cont_eql <= 1'b1;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef B06_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt_idx  <= gnt_n;
      ack      <= ack_n;
      eql      <= eql_n;
      cont_eql <= cont_eql_n;
      busy     <= busy_n;
      err      <= err_n;
`ifdef B06_ARB_TIMEOUT_EN
      cnt      <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_b06_arbiter.sv
// Directed self-checking bench for b06_arbiter; the handler is modelled by driving cc_mux/uscite.
module tb_b06_arbiter;
  import b06_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] ack;
  logic       eql, cont_eql, busy, err;
  logic [1:0] cc_mux, uscite;
  logic [1:0] gnt_idx;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  b06_arbiter #(.NREQ(4), .TIMEOUT(15)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .ack     (ack),
    .eql     (eql),
    .cont_eql(cont_eql),
    .cc_mux  (cc_mux),
    .uscite  (uscite),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; cc_mux = CC_NOP; uscite = OUT_NORM;
    step; step;
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", ack); end
    vectors++; if (eql !== 1'b0) begin miscompares++; $display("FAIL reset_eql: got %b want 0", eql); end
    vectors++; if (cont_eql !== 1'b1) begin miscompares++; $display("FAIL reset_cont_eql: got %b want 1", cont_eql); end
    vectors++; if (gnt_idx !== 2'd0) begin miscompares++; $display("FAIL reset_gnt: got %0d want 0", gnt_idx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0;
  endtask

  // Full handshake for one grant; called with the arbiter idle and req already driven.
  task automatic serve(input int unsigned exp, input bit rearm);
    logic [3:0] oh;
    oh = 4'b0001 << exp;
    step;
    vectors++; if (gnt_idx !== 2'(exp)) begin miscompares++; $display("FAIL serve_gnt: got %0d want %0d", gnt_idx, exp); end
    vectors++; if ({eql, cont_eql, busy} !== 3'b101) begin miscompares++; $display("FAIL serve_grant_outs: eql/cont/busy got %b want 101", {eql, cont_eql, busy}); end
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL serve_early_ack: got %b want 0000", ack); end
    cc_mux = CC_ACKIN;
    step;
    vectors++; if (ack !== oh) begin miscompares++; $display("FAIL serve_ack: got %b want %b", ack, oh); end
    vectors++; if ($countones(ack) > 1) begin miscompares++; $display("FAIL serve_onehot: got %b want at most one bit", ack); end
    req[exp] = 1'b0; cc_mux = CC_NOP;
    step;
    vectors++; if ({ack, eql, busy} !== 6'b000001) begin miscompares++; $display("FAIL serve_drop: ack/eql/busy got %b want 000001", {ack, eql, busy}); end
    step;
    vectors++; if ({busy, cont_eql} !== 2'b01) begin miscompares++; $display("FAIL serve_idle: busy/cont got %b want 01", {busy, cont_eql}); end
    if (rearm) req[exp] = 1'b1;
  endtask

  task automatic test_single;
    req = 4'b0010;
    serve(1, 1'b0);
    req = 4'b1011;   // ptr now 2: bit 3 wins, then wrap to 0, then 1
    serve(3, 1'b0);
    serve(0, 1'b0);
    serve(1, 1'b0);
  endtask

  task automatic test_withdrawal;
    req = 4'b0100;
    step;
    vectors++; if (gnt_idx !== 2'd2) begin miscompares++; $display("FAIL wd_gnt: got %0d want 2", gnt_idx); end
    req = 4'b0000; cc_mux = CC_ACKIN;
    step;
    vectors++; if ({ack, eql, busy} !== 6'b000001) begin miscompares++; $display("FAIL wd_outs: ack/eql/busy got %b want 000001", {ack, eql, busy}); end
    step;
    vectors++; if ({ack, busy} !== 5'b00001) begin miscompares++; $display("FAIL wd_drain_hold: ack/busy got %b want 00001", {ack, busy}); end
    cc_mux = CC_NOP;
    step;
    vectors++; if ({busy, cont_eql} !== 2'b01) begin miscompares++; $display("FAIL wd_idle: busy/cont got %b want 01", {busy, cont_eql}); end
    req = 4'b0101;   // ptr now 3: wraps to 0
    step;
    vectors++; if (gnt_idx !== 2'd0) begin miscompares++; $display("FAIL wd_wrap_gnt: got %0d want 0", gnt_idx); end
  endtask

  task automatic test_reset_in_ack;
    cc_mux = CC_ACKIN;
    step;
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL ria_ack: got %b want 0001", ack); end
    reset = 1'b1; cc_mux = CC_NOP;
    step;
    vectors++; if ({ack, eql, cont_eql, gnt_idx, busy, err} !== 10'b0000_0_1_00_0_0) begin
      miscompares++; $display("FAIL ria_outs: ack/eql/cont/gnt/busy/err got %b want 0000010000", {ack, eql, cont_eql, gnt_idx, busy, err});
    end
    reset = 1'b0; req = 4'b1001;   // ptr 0 picks 0; a stale ptr of 3 would pick 3
    step;
    vectors++; if (gnt_idx !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL ria_ptr: gnt/busy got %0d/%b want 0/1", gnt_idx, busy); end
    reset = 1'b1; req = '0;
    step;
    reset = 1'b0;
  endtask

  task automatic test_round_robin;
    reset = 1'b1; step; reset = 1'b0;
    req = 4'b1111;
    serve(0, 1'b1);
    serve(1, 1'b1);
    serve(2, 1'b1);
    serve(3, 1'b1);
    serve(0, 1'b0);
    req = '0;
  endtask

  task automatic test_timeout;
    reset = 1'b1; step; reset = 1'b0;
    cc_mux = CC_NOP; uscite = OUT_NORM; req = 4'b0001;
    step;
    vectors++; if (gnt_idx !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_grant: gnt/busy got %0d/%b want 0/1", gnt_idx, busy); end
`ifdef B06_ARB_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      step;
      vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_early: cycle %0d err/busy got %b/%b want 0/1", i, err, busy); end
    end
    step;
    vectors++; if ({err, busy, eql, cont_eql, ack} !== 8'b1001_0000) begin
      miscompares++; $display("FAIL to_abort: err/busy/eql/cont/ack got %b want 10010000", {err, busy, eql, cont_eql, ack});
    end
    step;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_pulse_width: got %b want 0", err); end
`else
    for (int i = 0; i < 100; i++) begin
      step;
      vectors++; if ({err, busy, eql, ack} !== 7'b0110000) begin
        miscompares++; $display("FAIL to_hold: cycle %0d err/busy/eql/ack got %b want 0110000", i, {err, busy, eql, ack});
      end
    end
`endif
    req = '0; reset = 1'b1; step; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; cc_mux = CC_NOP; uscite = OUT_NORM;
    @(negedge clock);
    test_reset;
    test_single;
    test_withdrawal;
    test_reset_in_ack;
    test_round_robin;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
